// File: rtl/pong_if.sv
// Raster position, player buttons and game status exchanged with pong_engine.
// master drives raster/buttons and observes status; slave is the game engine.
interface pong_if #(
   parameter int ROW_W   = 11,
   parameter int COL_W   = 11,
   parameter int SCORE_W = 4
);
   logic               start;
   logic               p1_up;
   logic               p1_down;
   logic               p2_up;
   logic               p2_down;
   logic [ROW_W-1:0]   row;
   logic [COL_W-1:0]   col;
   logic               pixel_on;
   logic [SCORE_W-1:0] score1;
   logic [SCORE_W-1:0] score2;
   logic [1:0]         state;
   logic               point_p1;
   logic               point_p2;

   modport master (
      output start, p1_up, p1_down, p2_up, p2_down, row, col,
      input  pixel_on, score1, score2, state, point_p1, point_p2
   );

   modport slave (
      input  start, p1_up, p1_down, p2_up, p2_down, row, col,
      output pixel_on, score1, score2, state, point_p1, point_p2
   );
endinterface

// File: rtl/pong_engine.sv
// Two-paddle pong core: motion, collisions, scoring and serve/win FSM advance once per frame tick.
// pixel_on is registered one cycle behind row/col; buttons add two cycles of synchronisation.
module pong_engine #(
   parameter int ACTIVE_COLS  = 640,
   parameter int ACTIVE_ROWS  = 480,
   parameter int TOTAL_COLS   = 800,
   parameter int TOTAL_ROWS   = 525,
   parameter int BORDER       = 3,
   parameter int PADDLE_X     = 16,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_H     = 64,
   parameter int BALL_SIZE    = 8,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4
) (
   input  logic  clk,
   input  logic  RESET,
   pong_if.slave bus
);
   localparam int ROW_W = $clog2(TOTAL_ROWS) + 1;
   localparam int COL_W = $clog2(TOTAL_COLS) + 1;
   localparam int SW    = ((ROW_W > COL_W) ? ROW_W : COL_W) + 1;
   localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

   typedef logic signed [SW-1:0] coord_t;
   typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, GAMEOVER = 2'd3} state_t;

   localparam coord_t AROWS     = coord_t'(ACTIVE_ROWS);
   localparam coord_t ACOLS     = coord_t'(ACTIVE_COLS);
   localparam coord_t BRD       = coord_t'(BORDER);
   localparam coord_t BSZ       = coord_t'(BALL_SIZE);
   localparam coord_t BSPD      = coord_t'(BALL_SPEED);
   localparam coord_t PSPD      = coord_t'(PADDLE_SPEED);
   localparam coord_t PH        = coord_t'(PADDLE_H);
   localparam coord_t PX        = coord_t'(PADDLE_X);
   localparam coord_t FACE_L    = coord_t'(PADDLE_X + PADDLE_W);
   localparam coord_t FACE_R    = coord_t'(ACTIVE_COLS - PADDLE_X - PADDLE_W);
   localparam coord_t PAD2_END  = coord_t'(ACTIVE_COLS - PADDLE_X);
   localparam coord_t X_CTR     = coord_t'((ACTIVE_COLS - BALL_SIZE) / 2);
   localparam coord_t Y_CTR     = coord_t'((ACTIVE_ROWS - BALL_SIZE) / 2);
   localparam coord_t BALL_YMAX = coord_t'(ACTIVE_ROWS - BORDER - BALL_SIZE);
   localparam coord_t PAD_YMAX  = coord_t'(ACTIVE_ROWS - BORDER - PADDLE_H);
   localparam coord_t PAD_Y0    = coord_t'((ACTIVE_ROWS - PADDLE_H) / 2);
   localparam coord_t NET_L     = coord_t'(ACTIVE_COLS / 2 - 1);
   localparam coord_t NET_R     = coord_t'(ACTIVE_COLS / 2);

   logic [4:0]         sync1_q, sync2_q;
   logic               start_s, p1u_s, p1d_s, p2u_s, p2d_s, tick;
   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   coord_t             bx_q, bx_d, by_q, by_d, p1_q, p1_d, p2_q, p2_d;
   logic               dx_q, dx_d, dy_q, dy_d;
   logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d, s1_inc, s2_inc;
   logic               pt1_q, pt1_d, pt2_q, pt2_d, pix_q, pix_d;
   coord_t             nx, ny, r, c;
   logic               hit1, hit2, miss_p1, miss_p2;

   assign {start_s, p1u_s, p1d_s, p2u_s, p2d_s} = sync2_q;
   assign tick = (bus.row == ROW_W'(ACTIVE_ROWS)) && (bus.col == '0);

   function automatic coord_t paddle_next(input coord_t y, input logic up, input logic dn);
      coord_t n;
      n = y;
      if (up && !dn) begin
         n = y - PSPD;
         if (n < BRD) n = BRD;
      end else if (dn && !up) begin
         n = y + PSPD;
         if (n > PAD_YMAX) n = PAD_YMAX;
      end
      return n;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bx_d    = bx_q;
      by_d    = by_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      pt1_d   = 1'b0;
      pt2_d   = 1'b0;
      s1_inc  = s1_q + 1'b1;
      s2_inc  = s2_q + 1'b1;
      nx      = dx_q ? bx_q + BSPD : bx_q - BSPD;
      ny      = dy_q ? by_q + BSPD : by_q - BSPD;
      hit1    = !dx_q && (nx <= FACE_L) && (by_q + BSZ > p1_q) && (by_q < p1_q + PH);
      hit2    = dx_q && (nx + BSZ >= FACE_R) && (by_q + BSZ > p2_q) && (by_q < p2_q + PH);
      miss_p1 = (nx + BSZ > ACOLS);
      miss_p2 = nx[SW-1];
      if (tick) begin
         if (state_q != GAMEOVER) begin
            p1_d = paddle_next(p1_q, p1u_s, p1d_s);
            p2_d = paddle_next(p2_q, p2u_s, p2d_s);
         end
         case (state_q)
            IDLE: begin
               bx_d = X_CTR;
               by_d = Y_CTR;
               s1_d = '0;
               s2_d = '0;
               cnt_d = '0;
               if (start_s) state_d = SERVE;
            end
            SERVE: begin
               bx_d = X_CTR;
               by_d = Y_CTR;
               if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                  cnt_d   = '0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PLAY: begin
               if (hit1) begin
                  bx_d = FACE_L;
                  dx_d = 1'b1;
               end else if (hit2) begin
                  bx_d = FACE_R - BSZ;
                  dx_d = 1'b0;
               end else if (miss_p1 || miss_p2) begin
                  // Serve heads toward the player who conceded; dy survives the point.
                  bx_d = X_CTR;
                  by_d = Y_CTR;
                  dx_d = miss_p1;
                  if (miss_p1) begin
                     s1_d    = s1_inc;
                     pt1_d   = 1'b1;
                     state_d = (s1_inc == SCORE_W'(WIN_SCORE)) ? GAMEOVER : SERVE;
                  end else begin
                     s2_d    = s2_inc;
                     pt2_d   = 1'b1;
                     state_d = (s2_inc == SCORE_W'(WIN_SCORE)) ? GAMEOVER : SERVE;
                  end
               end else begin
                  bx_d = nx;
               end
               if (!(hit1 || hit2) && (miss_p1 || miss_p2)) begin
                  by_d = Y_CTR;
               end else if (ny >= BALL_YMAX) begin
                  by_d = BALL_YMAX;
                  dy_d = 1'b0;
               end else if (ny <= BRD) begin
                  by_d = BRD;
                  dy_d = 1'b1;
               end else begin
                  by_d = ny;
               end
            end
            GAMEOVER: begin
               if (start_s) begin
                  state_d = IDLE;
                  s1_d    = '0;
                  s2_d    = '0;
                  dx_d    = 1'b1;
                  dy_d    = 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      r     = coord_t'(bus.row);
      c     = coord_t'(bus.col);
      pix_d = (r < AROWS) && (c < ACOLS) && (
                 ((c >= bx_q) && (c < bx_q + BSZ) && (r >= by_q) && (r < by_q + BSZ)) ||
                 ((c >= PX) && (c < FACE_L) && (r >= p1_q) && (r < p1_q + PH)) ||
                 ((c >= FACE_R) && (c < PAD2_END) && (r >= p2_q) && (r < p2_q + PH)) ||
                 (r < BRD) || (r >= AROWS - BRD) ||
                 (((c == NET_L) || (c == NET_R)) && !bus.row[3]));
   end

   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         bx_q    <= X_CTR;
         by_q    <= Y_CTR;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         p1_q    <= PAD_Y0;
         p2_q    <= PAD_Y0;
         s1_q    <= '0;
         s2_q    <= '0;
         pt1_q   <= 1'b0;
         pt2_q   <= 1'b0;
         pix_q   <= 1'b0;
      end else begin
         sync1_q <= {bus.start, bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down};
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         pt1_q   <= pt1_d;
         pt2_q   <= pt2_d;
         pix_q   <= pix_d;
      end
   end

   assign bus.pixel_on = pix_q;
   assign bus.score1   = s1_q;
   assign bus.score2   = s2_q;
   assign bus.state    = state_q;
   assign bus.point_p1 = pt1_q;
   assign bus.point_p2 = pt2_q;
endmodule
